// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the arithmetic datapath blocks (multiplier/divider).
//   - div_state_e : divider FSM state (IDLE/RUN/DONE, 2-bit encoding)
//   - N_DEF       : default operand width
//   - q_width / r_width / cnt_width : derived widths for a given N
//   - QW_DEF / RW_DEF / CNT_W_DEF   : those widths at the default N
// No ports (package).
// -----------------------------------------------------------------------------
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int N_DEF = 4;

  // Dividend / quotient width.
  function automatic int q_width(input int n);
    return 2 * n;
  endfunction

  // Partial remainder width: one guard bit above the divisor width.
  function automatic int r_width(input int n);
    return n + 1;
  endfunction

  // Iteration counter width, wide enough to hold 2N.
  function automatic int cnt_width(input int n);
    return $clog2(2 * n) + 1;
  endfunction

  localparam int QW_DEF    = q_width(N_DEF);
  localparam int RW_DEF    = r_width(N_DEF);
  localparam int CNT_W_DEF = cnt_width(N_DEF);

endpackage

// File: rtl/divider_4bit_if.sv
// -----------------------------------------------------------------------------
// divider_4bit_if
// Request/response bundle of the sequential divider.
//   start       : request, sampled only while the divider is idle
//   in_1 [2N]   : dividend
//   in_2 [N]    : divisor
//   out_q [2N]  : quotient (registered, held until next completion)
//   out_r [N]   : remainder (registered, held until next completion)
//   busy        : iterations in progress
//   done        : one-cycle completion pulse
//   div_by_zero : last completed division had a zero divisor
// Modports: master (requester side), slave (divider side).
// -----------------------------------------------------------------------------
interface divider_4bit_if #(
  parameter int N = 4
);

  logic             start;
  logic [2*N-1:0]   in_1;
  logic [N-1:0]     in_2;
  logic [2*N-1:0]   out_q;
  logic [N-1:0]     out_r;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, in_1, in_2,
    input  out_q, out_r, busy, done, div_by_zero
  );

  modport slave (
    input  start, in_1, in_2,
    output out_q, out_r, busy, done, div_by_zero
  );

endinterface

// File: rtl/divider_4bit_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
//   r_in    [N+1] : partial remainder before this step
//   bit_in        : next dividend bit (MSB first)
//   divisor [N]   : divisor
//   r_out   [N+1] : partial remainder after shift and conditional subtract
//   q_bit         : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
  parameter int N = 4
) (
  input  logic [N:0]   r_in,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N:0]   r_out,
  output logic         q_bit
);

  logic [N:0] shifted;

  always_comb begin
    shifted = {r_in[N-1:0], bit_in};
    // r_in[N] is always clear after a subtract; if it were ever set, the
    // shifted value would exceed any N-bit divisor, so it forces a 1.
    q_bit   = r_in[N] | (shifted >= {1'b0, divisor});
    r_out   = q_bit ? (shifted - {1'b0, divisor}) : shifted;
  end

endmodule

// File: rtl/divider_4bit.sv
// -----------------------------------------------------------------------------
// divider_4bit
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient
// bit per clock, MSB first, under a start/busy/done handshake.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : divider_4bit_if.slave (start, in_1, in_2 in; out_q, out_r, busy,
//         done, div_by_zero out)
// Timing: accept on edge k, busy k..k+2N, done pulse k+2N..k+2N+1.
// A zero divisor still runs all 2N iterations, then reports all-ones
// quotient, zero remainder and div_by_zero.
// -----------------------------------------------------------------------------
module divider_4bit
  import arith_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  divider_4bit_if.slave  bus
);

  localparam int QW = q_width(N);
  localparam int RW = r_width(N);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_ITER = CW'(QW - 1);

  div_state_e    state;
  div_state_e    state_nxt;

  // The dividend register doubles as the quotient register: each step shifts
  // out a dividend bit at the top and shifts in a quotient bit at the bottom.
  logic [QW-1:0] dvd;
  logic [N-1:0]  dvs;
  logic [RW-1:0] rem;
  logic [CW-1:0] cnt;
  logic          zero_flag;

  logic [RW-1:0] rem_nxt;
  logic          q_bit;
  logic          last_iter;

  div_step #(.N(N)) u_step (
    .r_in    (rem),
    .bit_in  (dvd[QW-1]),
    .divisor (dvs),
    .r_out   (rem_nxt),
    .q_bit   (q_bit)
  );

  assign last_iter = (cnt == LAST_ITER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd             <= '0;
      dvs             <= '0;
      rem             <= '0;
      cnt             <= '0;
      zero_flag       <= 1'b0;
      bus.out_q       <= '0;
      bus.out_r       <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            dvd       <= bus.in_1;
            dvs       <= bus.in_2;
            rem       <= '0;
            cnt       <= '0;
            zero_flag <= (bus.in_2 == '0);
          end
        end
        RUN: begin
          rem <= rem_nxt;
          dvd <= {dvd[QW-2:0], q_bit};
          cnt <= cnt + CW'(1);
          if (last_iter) begin
            if (zero_flag) begin
              bus.out_q       <= '1;
              bus.out_r       <= '0;
              bus.div_by_zero <= 1'b1;
            end else begin
              bus.out_q       <= {dvd[QW-2:0], q_bit};
              bus.out_r       <= rem_nxt[N-1:0];
              bus.div_by_zero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
